// File: rtl/midi_note_rx.sv
// MIDI serial receiver and monophonic note/gate decoder driving the synth voice.
// Last-note priority; a release only closes the gate for the key currently sounding.
module midi_note_rx #(
    parameter int CLKSPEED = 48_000_000,
    parameter int BAUD     = 31250,
    parameter int CHANNEL  = 0,
    parameter int OMNI     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       midi_rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       gate,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic [9:0] amp,
    output logic       note_on_stb
);

    localparam int CPB = CLKSPEED / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW = $clog2(CPB + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CPB - 1);
    localparam logic [3:0] CH = 4'(CHANNEL);

    typedef enum logic [2:0] {
        ST_ARM   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } rx_state_t;

    logic       sync1_r;
    logic       rxs_r;
    rx_state_t  state_r;
    rx_state_t  state_nx_s;
    logic [CW-1:0] cnt_r;
    logic [2:0] bitn_r;
    logic [7:0] shreg_r;
    logic       cnt_done_s;
    logic       byte_ok_s;
    logic       byte_bad_s;
    logic [7:0] run_status_r;
    logic       dcnt_r;
    logic [6:0] key_r;
    logic       is_rt_s;
    logic       is_sys_s;
    logic       msg_ok_s;
    logic       note_on_s;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= midi_rx;
            rxs_r   <= sync1_r;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_ARM;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Receiver next-state logic.
    always_comb begin
        cnt_done_s = ((state_r == ST_START) && (cnt_r == HALF_LAST)) ||
                     (((state_r == ST_DATA) || (state_r == ST_STOP)) && (cnt_r == BIT_LAST));
        state_nx_s = state_r;
        case (state_r)
            ST_ARM:   state_nx_s = rxs_r ? ST_IDLE : ST_ARM;
            ST_IDLE:  state_nx_s = rxs_r ? ST_IDLE : ST_START;
            ST_START: begin
                if (cnt_done_s) begin
                    state_nx_s = rxs_r ? ST_IDLE : ST_DATA;
                end else begin
                    state_nx_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_done_s && (bitn_r == 3'd7)) begin
                    state_nx_s = ST_STOP;
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (cnt_done_s) begin
                    state_nx_s = rxs_r ? ST_IDLE : ST_ARM;
                end else begin
                    state_nx_s = ST_STOP;
                end
            end
            default:  state_nx_s = ST_ARM;
        endcase
    end

    // Receiver output decode: stop-bit verdict.
    always_comb begin
        byte_ok_s  = (state_r == ST_STOP) && cnt_done_s && rxs_r;
        byte_bad_s = (state_r == ST_STOP) && cnt_done_s && !rxs_r;
    end

    // Bit timing counter, bit index and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= '0;
            bitn_r  <= 3'd0;
            shreg_r <= 8'h00;
        end else begin
            if (cnt_done_s || (state_r == ST_IDLE) || (state_r == ST_ARM)) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + 1'b1;
            end
            if (state_r == ST_IDLE) begin
                bitn_r <= 3'd0;
            end else if ((state_r == ST_DATA) && cnt_done_s) begin
                bitn_r  <= bitn_r + 3'd1;
                shreg_r <= {rxs_r, shreg_r[7:1]};
            end
        end
    end

    // Registered receiver outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            byte_data  <= 8'h00;
        end else begin
            byte_valid <= byte_ok_s;
            frame_err  <= byte_bad_s;
            if (byte_ok_s) begin
                byte_data <= shreg_r;
            end
        end
    end

    // Byte classification against the current running status.
    always_comb begin
        is_rt_s   = (byte_data[7:3] == 5'b11111);
        is_sys_s  = (byte_data[7:4] == 4'hF);
        msg_ok_s  = ((run_status_r[7:4] == 4'h8) || (run_status_r[7:4] == 4'h9)) &&
                    ((OMNI != 0) || (run_status_r[3:0] == CH));
        note_on_s = (run_status_r[7:4] == 4'h9) && (byte_data != 8'h00);
    end

    // Message parser and note/gate state; real-time bytes pass through untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_status_r <= 8'h00;
            dcnt_r       <= 1'b0;
            key_r        <= 7'd0;
            gate         <= 1'b0;
            note         <= 7'd0;
            velocity     <= 7'd0;
            note_on_stb  <= 1'b0;
        end else begin
            note_on_stb <= 1'b0;
            if (byte_valid) begin
                if (!byte_data[7]) begin
                    if (msg_ok_s) begin
                        if (!dcnt_r) begin
                            key_r  <= byte_data[6:0];
                            dcnt_r <= 1'b1;
                        end else begin
                            dcnt_r <= 1'b0;
                            if (note_on_s) begin
                                note        <= key_r;
                                velocity    <= byte_data[6:0];
                                gate        <= 1'b1;
                                note_on_stb <= 1'b1;
                            end else if (gate && (key_r == note)) begin
                                gate <= 1'b0;
                            end
                        end
                    end
                end else if (is_sys_s) begin
                    if (!is_rt_s) begin
                        run_status_r <= 8'h00;
                        dcnt_r       <= 1'b0;
                    end
                end else begin
                    run_status_r <= byte_data;
                    dcnt_r       <= 1'b0;
                end
            end
        end
    end

    // Amplitude follows gate and velocity one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            amp <= 10'd0;
        end else begin
            amp <= gate ? {velocity, velocity[6:4]} : 10'd0;
        end
    end

endmodule

// File: tb/tb_midi_note_rx.sv
// Directed and randomized byte streams against a byte-level reference model of the note decoder.
module tb_midi_note_rx;

    localparam int CLKSPEED = 1_000_000;
    localparam int BAUD = 31250;
    localparam int CPB = CLKSPEED / BAUD;
    localparam int HALF = CPB / 2;

    logic       clk;
    logic       rst;
    logic       midi_rx;
    logic [1:0] bv_w;
    logic [1:0] fe_w;
    logic [1:0] gate_w;
    logic [1:0] stb_w;
    logic [7:0] bd_w [2];
    logic [6:0] note_w [2];
    logic [6:0] vel_w [2];
    logic [9:0] amp_w [2];

    midi_note_rx #(.CLKSPEED(CLKSPEED), .BAUD(BAUD), .CHANNEL(0), .OMNI(0)) dut0 (
        .clk(clk), .rst(rst), .midi_rx(midi_rx),
        .byte_valid(bv_w[0]), .byte_data(bd_w[0]), .frame_err(fe_w[0]),
        .gate(gate_w[0]), .note(note_w[0]), .velocity(vel_w[0]),
        .amp(amp_w[0]), .note_on_stb(stb_w[0])
    );

    midi_note_rx #(.CLKSPEED(CLKSPEED), .BAUD(BAUD), .CHANNEL(0), .OMNI(1)) dut1 (
        .clk(clk), .rst(rst), .midi_rx(midi_rx),
        .byte_valid(bv_w[1]), .byte_data(bd_w[1]), .frame_err(fe_w[1]),
        .gate(gate_w[1]), .note(note_w[1]), .velocity(vel_w[1]),
        .amp(amp_w[1]), .note_on_stb(stb_w[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_t0 = 0;
    int last_bv = 0;
    int bv_cnt [2] = '{0, 0};
    int fe_cnt [2] = '{0, 0};
    int stb_cnt [2] = '{0, 0};

    // reference model state, one per decoder instance
    int m_omni [2] = '{0, 1};
    int m_rs [2];
    int m_dcnt [2];
    int m_key [2];
    int m_gate [2];
    int m_note [2];
    int m_vel [2];
    int m_stb [2] = '{0, 0};
    int exp_bv = 0;
    int exp_fe = 0;
    int m_last = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // edge counter and pulse counters, sampling pre-edge values
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (bv_w[i]) bv_cnt[i] = bv_cnt[i] + 1;
            if (fe_w[i]) fe_cnt[i] = fe_cnt[i] + 1;
            if (stb_w[i]) stb_cnt[i] = stb_cnt[i] + 1;
        end
        if (bv_w[0]) last_bv = cyc;
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_rs[i] = 0; m_dcnt[i] = 0; m_key[i] = 0;
            m_gate[i] = 0; m_note[i] = 0; m_vel[i] = 0;
        end
        m_last = 0;
    endtask

    task automatic model_byte(input int b);
        m_last = b;
        for (int i = 0; i < 2; i++) begin
            if (b >= 'hF8) begin
            end else if (b >= 'hF0) begin
                m_rs[i] = 0; m_dcnt[i] = 0;
            end else if (b >= 'h80) begin
                m_rs[i] = b; m_dcnt[i] = 0;
            end else if ((m_rs[i] / 16 == 8 || m_rs[i] / 16 == 9) &&
                         (m_omni[i] == 1 || m_rs[i] % 16 == 0)) begin
                if (m_dcnt[i] == 0) begin
                    m_key[i] = b; m_dcnt[i] = 1;
                end else begin
                    m_dcnt[i] = 0;
                    if (m_rs[i] / 16 == 9 && b > 0) begin
                        m_note[i] = m_key[i]; m_vel[i] = b; m_gate[i] = 1;
                        m_stb[i] = m_stb[i] + 1;
                    end else if (m_gate[i] == 1 && m_key[i] == m_note[i]) begin
                        m_gate[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s.gate%0d", tag, i), 32'(gate_w[i]), 32'(m_gate[i]));
            check($sformatf("%s.note%0d", tag, i), 32'(note_w[i]), 32'(m_note[i]));
            check($sformatf("%s.vel%0d", tag, i), 32'(vel_w[i]), 32'(m_vel[i]));
            check($sformatf("%s.amp%0d", tag, i), 32'(amp_w[i]),
                  32'(m_gate[i] == 1 ? m_vel[i] * 8 + m_vel[i] / 16 : 0));
            check($sformatf("%s.stb%0d", tag, i), 32'(stb_cnt[i]), 32'(m_stb[i]));
            check($sformatf("%s.data%0d", tag, i), 32'(bd_w[i]), 32'(m_last));
            check($sformatf("%s.bv%0d", tag, i), 32'(bv_cnt[i]), 32'(exp_bv));
            check($sformatf("%s.fe%0d", tag, i), 32'(fe_cnt[i]), 32'(exp_fe));
        end
    endtask

    // Drive one 10-bit frame starting at a negedge; stop_ok=0 leaves the line low.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        midi_rx = 1'b0;
        last_t0 = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            midi_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        midi_rx = stop_ok;
        repeat (CPB) @(negedge clk);
        if (stop_ok) begin
            midi_rx = 1'b1;
            exp_bv++;
            model_byte(int'(b));
        end else begin
            exp_fe++;
        end
    endtask

    task automatic send_seq(input string tag, input logic [7:0] seq [$]);
        foreach (seq[k]) begin
            send_byte(seq[k], 1'b1);
            check_state($sformatf("%s[%0d]", tag, k));
        end
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b1;
        midi_rx = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        check_state("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        send_seq("noteon", '{8'h90, 8'h3C, 8'h64});
        check("bv_timing", 32'(last_bv - last_t0), 32'(3 + HALF + 9 * CPB));

        send_seq("running", '{8'h40, 8'h50, 8'h3C, 8'h00});
        send_seq("release", '{8'h40, 8'h00});

        send_seq("chan", '{8'h91, 8'h3C, 8'h64});
        send_seq("rt", '{8'h90, 8'h3C, 8'hF8, 8'h64});

        send_byte(8'h90, 1'b0);
        check_state("ferr");
        repeat (3 * CPB) @(negedge clk);
        check_state("ferr_hold");
        midi_rx = 1'b1;
        repeat (4) @(negedge clk);
        send_seq("after_ferr", '{8'h80, 8'h3C, 8'h40});

        midi_rx = 1'b0;
        repeat (HALF / 2 + 2) @(negedge clk);
        midi_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_state("glitch");
        send_seq("syscommon", '{8'h90, 8'h3C, 8'hF2, 8'h64});

        send_seq("pre_rst", '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3C});
        midi_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        repeat (CPB + CPB / 2) @(negedge clk);
        rst = 1'b1;
        midi_rx = 1'b1;
        @(negedge clk);
        model_reset();
        check_state("midrst");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send_seq("nostatus", '{8'h3C, 8'h64});

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0: b = 8'h90;
                1: b = 8'h80;
                2: b = 8'h91;
                3: b = 8'h81;
                4: b = 8'hF8;
                5: b = 8'hF2;
                6: b = 8'hB0;
                7: b = 8'h3C;
                8: b = 8'h00;
                default: b = 8'($urandom_range(0, 127));
            endcase
            send_byte(b, 1'b1);
            check_state($sformatf("rand[%0d]", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
